// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encodings, redirect priorities and PC constants
package pc_seq_pkg;

   // Debug-visible FSM encoding; the numeric values are exported on the state port.
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_STALL = 2'd2,
      ST_HALT  = 2'd3
   } pc_state_t;

   // Redirect sources ranked so that a larger value always wins.
   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_BR   = 2'd1,
      RD_JMP  = 2'd2,
      RD_EXC  = 2'd3
   } redir_prio_t;

   localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_EXC_VEC_DEF   = 32'h0000_0080;
   localparam logic [31:0] PC_INCR          = 32'd4;

   // Redirect targets are word aligned regardless of what the source drives.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational redirect priority merge and sequential PC
module pc_next_sel
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] EXC_VEC = PC_EXC_VEC_DEF
) (
   input  logic [31:0] pc,
   input  redir_prio_t pend_prio,
   input  logic [31:0] pend_target,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   input  logic        exc,
   output logic [31:0] seq_pc,
   output logic        redir,
   output redir_prio_t sel_prio,
   output logic [31:0] sel_target
);

   redir_prio_t in_prio;
   logic [31:0] in_target;

   // Pick the strongest redirect arriving this cycle: exc over jmp over branch.
   always_comb begin
      in_prio   = RD_NONE;
      in_target = '0;
      if (exc) begin
         in_prio   = RD_EXC;
         in_target = align_word(EXC_VEC);
      end else if (jmp) begin
         in_prio   = RD_JMP;
         in_target = align_word(jmp_target);
      end else if (br_taken) begin
         in_prio   = RD_BR;
         in_target = align_word(br_target);
      end
   end

   // A new redirect of equal or higher rank replaces the pending one.
   always_comb begin
      sel_prio   = in_prio;
      sel_target = in_target;
      if (pend_prio > in_prio) begin
         sel_prio   = pend_prio;
         sel_target = pend_target;
      end
      redir = (sel_prio != RD_NONE);
   end

   assign seq_pc = pc + PC_INCR;

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program counter sequencer with fetch handshake, redirects and halt
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = PC_RESET_VEC_DEF,
   parameter logic [31:0] EXC_VEC   = PC_EXC_VEC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   input  logic        exc,
   input  logic        halt,
   output logic [31:0] pc_out,
   output logic        instr_valid,
   output logic [31:0] instr_pc,
   output logic [1:0]  state
);

   pc_state_t   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   redir_prio_t pend_prio_q, pend_prio_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;
   logic        halt_q, halt_d;
   logic        iv_q, iv_d;
   logic [31:0] ipc_q, ipc_d;

   logic        halt_seen;
   logic        redir;
   redir_prio_t sel_prio;
   logic [31:0] sel_target;
   logic [31:0] seq_pc;

   pc_next_sel #(
      .EXC_VEC(EXC_VEC)
   ) u_next_sel (
      .pc         (pc_q),
      .pend_prio  (pend_prio_q),
      .pend_target(pend_tgt_q),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .exc        (exc),
      .seq_pc     (seq_pc),
      .redir      (redir),
      .sel_prio   (sel_prio),
      .sel_target (sel_target)
   );

   // A halt request seen this cycle counts as if it were already held.
   assign halt_seen = halt_q | halt;

   // Next-state, next-PC and completion pulse selection.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_prio_d = pend_prio_q;
      pend_tgt_d  = pend_tgt_q;
      halt_d      = halt_seen;
      iv_d        = 1'b0;
      ipc_d       = ipc_q;
      case (state_q)
         ST_BOOT: begin
            state_d = halt_seen ? ST_HALT : ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               if (redir) begin
                  pc_d = sel_target;
               end else begin
                  iv_d  = 1'b1;
                  ipc_d = pc_q;
                  pc_d  = seq_pc;
               end
               pend_prio_d = RD_NONE;
               if (halt_seen)
                  state_d = ST_HALT;
               else if (stall)
                  state_d = ST_STALL;
               else
                  state_d = ST_FETCH;
            end else if (redir) begin
               pend_prio_d = sel_prio;
               pend_tgt_d  = sel_target;
            end
         end
         ST_STALL: begin
            if (redir)
               pc_d = sel_target;
            if (halt_seen)
               state_d = ST_HALT;
            else if (!stall)
               state_d = ST_FETCH;
         end
         ST_HALT: begin
            if (exc) begin
               pc_d    = align_word(EXC_VEC);
               state_d = ST_FETCH;
               halt_d  = 1'b0;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   // State and PC registers; reset aborts any outstanding request at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_VEC;
         pend_prio_q <= RD_NONE;
         pend_tgt_q  <= '0;
         halt_q      <= 1'b0;
         iv_q        <= 1'b0;
         ipc_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_prio_q <= pend_prio_d;
         pend_tgt_q  <= pend_tgt_d;
         halt_q      <= halt_d;
         iv_q        <= iv_d;
         ipc_q       <= ipc_d;
      end
   end

   assign imem_req    = (state_q == ST_FETCH);
   assign imem_addr   = pc_q;
   assign pc_out      = pc_q;
   assign instr_valid = iv_q;
   assign instr_pc    = ipc_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - self-checking bench for pc_seq with a behavioural reference model
module tb_pc_seq;

   localparam logic [31:0] M_RESET = 32'h0000_0000;
   localparam logic [31:0] M_EXC   = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [31:0] jmp_target;
   logic        exc;
   logic        halt;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic [31:0] instr_pc;
   logic [1:0]  state;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on   = 1'b0;

   // model: mode 0 boot, 1 fetching, 2 stalled, 3 halted
   int          m_mode;
   logic [31:0] m_pc;
   int          m_pend_rank;
   logic [31:0] m_pend_addr;
   bit          m_halt_req;
   bit          m_iv;
   logic [31:0] m_ipc;

   pc_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .exc        (exc),
      .halt       (halt),
      .pc_out     (pc_out),
      .instr_valid(instr_valid),
      .instr_pc   (instr_pc),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode      = 0;
      m_pc        = M_RESET;
      m_pend_rank = 0;
      m_pend_addr = '0;
      m_halt_req  = 1'b0;
      m_iv        = 1'b0;
      m_ipc       = '0;
   endtask

   task automatic model_step();
      int          rank;
      logic [31:0] tgt;
      bit          want_halt;
      rank = 0;
      tgt  = '0;
      if (br_taken) begin rank = 1; tgt = br_target & 32'hFFFF_FFFC; end
      if (jmp)      begin rank = 2; tgt = jmp_target & 32'hFFFF_FFFC; end
      if (exc)      begin rank = 3; tgt = M_EXC; end
      if (m_pend_rank > rank) begin rank = m_pend_rank; tgt = m_pend_addr; end
      want_halt  = m_halt_req || halt;
      m_halt_req = want_halt;
      m_iv       = 1'b0;
      if (m_mode == 0) begin
         m_mode = want_halt ? 3 : 1;
      end else if (m_mode == 1) begin
         if (imem_ack) begin
            if (rank != 0) begin
               m_pc = tgt;
            end else begin
               m_iv  = 1'b1;
               m_ipc = m_pc;
               m_pc  = m_pc + 32'd4;
            end
            m_pend_rank = 0;
            m_mode = want_halt ? 3 : (stall ? 2 : 1);
         end else if (rank != 0) begin
            m_pend_rank = rank;
            m_pend_addr = tgt;
         end
      end else if (m_mode == 2) begin
         if (rank != 0) m_pc = tgt;
         m_mode = want_halt ? 3 : (stall ? 2 : 1);
      end else begin
         if (exc) begin
            m_pc       = M_EXC;
            m_mode     = 1;
            m_halt_req = 1'b0;
         end
      end
   endtask

   // Advance the reference model on each clock, or reset it with the DUT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // Compare every DUT output with the model away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         check("m_imem_req",    32'(imem_req),    32'(m_mode == 1));
         check("m_imem_addr",   imem_addr,        m_pc);
         check("m_pc_out",      pc_out,           m_pc);
         check("m_state",       32'(state),       32'(m_mode));
         check("m_instr_valid", 32'(instr_valid), 32'(m_iv));
         check("m_instr_pc",    instr_pc,         m_ipc);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      imem_ack = 1'b0; stall = 1'b0; br_taken = 1'b0; jmp = 1'b0;
      exc = 1'b0; halt = 1'b0; br_target = '0; jmp_target = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk_on = 1'b1;

      check("rst_pc",    pc_out, 32'h0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_req",   32'(imem_req), 32'd0);
      check("rst_iv",    32'(instr_valid), 32'd0);
      check("rst_ipc",   instr_pc, 32'h0);

      // reset release with ack held high
      imem_ack = 1'b1;
      rst_n    = 1'b1;
      #1;
      check("boot_state", 32'(state), 32'd0);
      check("boot_req",   32'(imem_req), 32'd0);
      tick();
      check("boot_to_fetch", 32'(state), 32'd1);
      check("fetch_req",     32'(imem_req), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("seq_iv",  32'(instr_valid), 32'd1);
         check("seq_ipc", instr_pc, 32'(i * 4));
      end

      // delayed ack at pc 8
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      imem_ack = 1'b0;
      check("wait_addr0", imem_addr, 32'h8);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("wait_addr", imem_addr, 32'h8);
         check("wait_iv",   32'(instr_valid), 32'd0);
      end
      imem_ack = 1'b1;
      tick();
      check("late_iv",  32'(instr_valid), 32'd1);
      check("late_ipc", instr_pc, 32'h8);
      check("late_pc",  pc_out, 32'hC);
      imem_ack = 1'b0;
      tick();
      check("late_pulse_end", 32'(instr_valid), 32'd0);

      // pending branch overwritten by jump, later branch cannot override it
      br_taken = 1'b1; br_target = 32'h40;
      tick();
      br_taken = 1'b0;
      jmp = 1'b1; jmp_target = 32'h80;
      tick();
      jmp = 1'b0;
      check("pend_hold_addr", imem_addr, 32'hC);
      br_taken = 1'b1; br_target = 32'h44;
      imem_ack = 1'b1;
      tick();
      br_taken = 1'b0;
      check("squash_iv",   32'(instr_valid), 32'd0);
      check("squash_addr", imem_addr, 32'h80);

      // stall after ack at 0x10, branch applied while stalled
      jmp = 1'b1; jmp_target = 32'h10;
      tick();
      jmp = 1'b0;
      check("jmp_pc", pc_out, 32'h10);
      stall = 1'b1;
      tick();
      check("stall_state", 32'(state), 32'd2);
      check("stall_ipc",   instr_pc, 32'h10);
      check("stall_req0",  32'(imem_req), 32'd0);
      imem_ack = 1'b0;
      br_taken = 1'b1; br_target = 32'h103;
      for (int i = 0; i < 3; i++) begin
         tick();
         br_taken = 1'b0;
         check("stall_req", 32'(imem_req), 32'd0);
      end
      check("stall_br_pc", pc_out, 32'h100);
      stall = 1'b0;
      tick();
      check("resume_state", 32'(state), 32'd1);
      check("resume_addr",  imem_addr, 32'h100);

      // wrap at top of address space, then halt and exception exit
      jmp = 1'b1; jmp_target = 32'hFFFF_FFFF; imem_ack = 1'b1;
      tick();
      jmp = 1'b0;
      check("top_pc", pc_out, 32'hFFFF_FFFC);
      halt = 1'b1;
      tick();
      halt = 1'b0; imem_ack = 1'b0;
      check("wrap_pc",    pc_out, 32'h0);
      check("wrap_ipc",   instr_pc, 32'hFFFF_FFFC);
      check("halt_state", 32'(state), 32'd3);
      tick();
      check("halt_req", 32'(imem_req), 32'd0);
      imem_ack = 1'b1;
      tick();
      check("halt_hold_pc", pc_out, 32'h0);
      check("halt_no_iv",   32'(instr_valid), 32'd0);
      imem_ack = 1'b0;
      exc = 1'b1;
      tick();
      exc = 1'b0;
      check("exc_pc",    pc_out, 32'h80);
      check("exc_state", 32'(state), 32'd1);

      // reset mid-wait at 0x20
      jmp = 1'b1; jmp_target = 32'h20; imem_ack = 1'b1;
      tick();
      jmp = 1'b0; imem_ack = 1'b0;
      tick();
      check("mid_addr", imem_addr, 32'h20);
      imem_ack = 1'b1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_pc",  pc_out, 32'h0);
      check("mid_rst_req", 32'(imem_req), 32'd0);
      tick();
      check("mid_rst_iv", 32'(instr_valid), 32'd0);
      rst_n = 1'b1;
      idle_inputs();

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         imem_ack   = ($urandom_range(0, 99) < 60);
         stall      = ($urandom_range(0, 99) < 25);
         br_taken   = ($urandom_range(0, 99) < 12);
         jmp        = ($urandom_range(0, 99) < 7);
         exc        = ($urandom_range(0, 99) < 5);
         halt       = ($urandom_range(0, 99) < 3);
         br_target  = $urandom;
         jmp_target = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFD : $urandom;
         if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
         tick();
         rst_n = 1'b1;
      end

      idle_inputs();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter EXC_VEC, default 32'h0000_0080, exception redirect address.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  out  32  fetch address, equal to pc_out.
REQ-007 SHALL have port imem_ack  in  1  memory accepted and completed the current request.
REQ-008 SHALL have port stall  in  1  downstream cannot accept another instruction.
REQ-009 SHALL have port br_taken / br_target  in  1 / 32  branch redirect pulse and target.
REQ-010 SHALL have port jmp / jmp_target  in  1 / 32  jump redirect pulse and target.
REQ-011 SHALL have port exc  in  1  exception pulse, redirect to EXC_VEC.
REQ-012 SHALL have port halt  in  1  stop fetching after the current request.
REQ-013 SHALL have port pc_out  out  32  current PC register.
REQ-014 SHALL have port instr_valid / instr_pc  out  1 / 32  one-cycle pulse marking a non-squashed completed fetch, and its address.
REQ-015 SHALL have port state  out  2  FSM state encoding for debug.

Function
REQ-016 FSM states SHALL be BOOT=0, FETCH=1, STALL=2, HALT=3.
REQ-017 BOOT SHALL last exactly one cycle after reset release, with imem_req=0, then go to FETCH.
REQ-018 In FETCH, imem_req SHALL be 1, and imem_addr SHALL stay stable until imem_ack.
REQ-019 Redirect priority SHALL be exc > jmp > br_taken; targets SHALL have bits [1:0] forced to 00.
REQ-020 Sequential next PC SHALL be pc_out+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-021 A redirect in FETCH without imem_ack SHALL be latched into a pending register; a later, higher-or-equal-priority redirect SHALL overwrite it.
REQ-022 On imem_ack with a redirect pending or arriving that cycle: pc_out SHALL take the redirect target, instr_valid SHALL stay 0 (squash), and the pending register SHALL clear.
REQ-023 On imem_ack with no redirect: instr_valid=1, instr_pc=pc_out, and pc_out SHALL become pc_out+4 on the next edge.
REQ-024 On an unsquashed or squashed ack with stall=1, the FSM SHALL go to STALL; otherwise it SHALL remain in FETCH. Back-to-back requests SHALL be allowed.
REQ-025 In STALL, imem_req SHALL be 0; redirects SHALL update pc_out immediately; the FSM SHALL return to FETCH the cycle after stall=0.
REQ-026 halt SHALL be sampled and held (sticky); the FSM SHALL enter HALT at the next imem_ack, or immediately if in STALL/BOOT.
REQ-027 In HALT, imem_req SHALL be 0 and pc_out SHALL hold; only exc SHALL exit, setting pc_out=EXC_VEC, going to FETCH and clearing the sticky halt.
REQ-028 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-029 On rst_n=0: pc_out=RESET_VEC, state=BOOT, imem_req=0, instr_valid=0, instr_pc=0, pending redirect and sticky halt cleared.
REQ-030 Reset asserted mid-request SHALL abort the request immediately; no instr_valid pulse SHALL occur.

Structure
REQ-031 State encodings, the default RESET_VEC/EXC_VEC values and the PC increment constant 4 SHALL live in a shared package pc_seq_pkg.
REQ-032 Combinational next-PC priority selection SHALL be a sub-module pc_next_sel; the FSM and registers SHALL stay in pc_seq.

Verification
REQ-033 Reset release, imem_ack held 1 -> BOOT 1 cycle, then instr_pc 0,4,8,12 on consecutive cycles.
REQ-034 Ack delayed 3 cycles at pc=8 -> imem_addr=8 stable for 3 cycles, one instr_valid pulse with instr_pc=8.
REQ-035 br_taken (target 0x40) then jmp (target 0x80) while waiting, exc absent -> fetch at pc squashed, next imem_addr=0x80.
REQ-036 stall=1 at ack of pc=0x10 for 4 cycles, br_taken target 0x103 in STALL -> imem_req=0 for 4 cycles, resume with imem_addr=0x100.
REQ-037 pc=32'hFFFF_FFFC acked -> pc_out=0; halt then exc -> HALT holds pc, exc sets pc_out=0x80 and state=FETCH.
REQ-038 rst_n low mid-wait at pc=0x20 -> pc_out=RESET_VEC, imem_req=0, no instr_valid.
